// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage iterative multiply/divide unit owning HI/LO
// Radix-2 shift-add multiply and restoring divide; one step per cycle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 div_q, div_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 is_md, issue, op_signed, op_div;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, step, prod;
  logic [WIDTH-1:0]     quot, rem;

  always_comb begin
    is_md     = start && (op >= OP_MULT) && (op <= OP_DIVU);
    issue     = (state_q == S_IDLE) && is_md && !flush;
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    // Most-negative input maps to itself, which is the correct unsigned magnitude.
    mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // Divide: acc = {partial remainder, dividend/quotient bits}.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step      = div_q ? div_next : mul_next;

    prod      = (sa_q ^ sb_q) ? -step : step;
    quot      = (sa_q ^ sb_q) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem       = sa_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (is_md) begin
            if (op_div && (b == '0)) begin
              hi_d    = a;
              lo_d    = '1;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
              opnd_d  = op_div ? mag_b : mag_a;
              div_d   = op_div;
              sa_d    = op_signed && a[WIDTH-1];
              sb_d    = op_signed && b[WIDTH-1];
              count_d = '0;
              state_d = S_CALC;
            end
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = step;
          count_d = count_q + CW'(1);
          if (count_q == LAST) begin
            hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d    = div_q ? quot : prod[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign stall_req = issue || (state_q == S_CALC);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
// Table of mul/div vectors plus hand-written flush, MTHI/MTLO and async-reset sequences.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .a(a), .b(b), .stall_req(stall_req), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                        input int estalls);
    int stalls;
    int cyc;
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    stalls = 0;
    cyc    = 0;
    #1;
    while (stall_req && cyc < 100) begin
      stalls++;
      tick();
      cyc++;
    end
    check({name, " stall_cycles"}, 32'(stalls), 32'(estalls));
    check({name, " done_pulse"}, {31'd0, done}, 32'd1);
    check({name, " busy_in_done"}, {31'd0, busy}, 32'd1);
    tick();
    start = 1'b0;
    op    = 3'd0;
    #1;
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
    check({name, " done_clear"}, {31'd0, done}, 32'd0);
    check({name, " busy_after1"}, {31'd0, busy}, 32'd0);
    tick();
    check({name, " busy_after2"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
    vecs[4]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6]  = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[7]  = '{3'd4, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
    vecs[8]  = '{3'd1, 32'd2,        32'd3,        32'd0,        32'd6,        33};
    vecs[9]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        33};
    vecs[11] = '{3'd4, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 33};

    rst = 1'b1; flush = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall_req}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].stalls);
    end

    // MTHI / MTLO: single-cycle write, no stall, no done
    start = 1'b1; op = 3'd5; a = 32'h1234;
    #1;
    check("mthi stall", {31'd0, stall_req}, 32'd0);
    tick();
    op = 3'd6; a = 32'h5678;
    #1;
    check("mthi hi", hi, 32'h1234);
    check("mthi busy", {31'd0, busy}, 32'd0);
    check("mtlo stall", {31'd0, stall_req}, 32'd0);
    tick();
    start = 1'b0; op = 3'd0;
    #1;
    check("mtlo lo", lo, 32'h5678);
    check("mtlo done", {31'd0, done}, 32'd0);

    // flush at CALC cycle 10 aborts the divide
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("pre_flush busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0; op = 3'd0;
    #1;
    check("flush stall", {31'd0, stall_req}, 32'd0);
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush hi", hi, 32'h1234);
    check("flush lo", lo, 32'h5678);
    check("flush done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) check("flush late_done", {31'd0, done}, 32'd0);
    end
    check("flush hi_later", hi, 32'h1234);

    // flush in IDLE suppresses the issue
    start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3; flush = 1'b1;
    #1;
    check("idle_flush stall", {31'd0, stall_req}, 32'd0);
    tick();
    start = 1'b0; flush = 1'b0; op = 3'd0;
    #1;
    check("idle_flush busy", {31'd0, busy}, 32'd0);

    // async reset mid-CALC
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd7;
    tick();
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1; start = 1'b0; op = 3'd0;
    #1;
    check("arst stall", {31'd0, stall_req}, 32'd0);
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst hi", hi, 32'd0);
    check("arst lo", lo, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_md("post_rst", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
